// File: rtl/interval_timer_arbiter_if.sv
// Request/grant bundle between requesters and the interval timer arbiter.
// The abort signal exists only when TIMER_ABORT_EN is defined.
interface interval_timer_arbiter_if;
    logic [2:0] req;
    logic [3:0] dur0;
    logic [3:0] dur1;
    logic [3:0] dur2;
    logic [2:0] gnt;
    logic       busy;
    logic [2:0] done;
    logic [3:0] q;
`ifdef TIMER_ABORT_EN
    logic       abort;

    modport master (
        output req, dur0, dur1, dur2, abort,
        input  gnt, busy, done, q
    );
    modport slave (
        input  req, dur0, dur1, dur2, abort,
        output gnt, busy, done, q
    );
`else
    modport master (
        output req, dur0, dur1, dur2,
        input  gnt, busy, done, q
    );
    modport slave (
        input  req, dur0, dur1, dur2,
        output gnt, busy, done, q
    );
`endif
endinterface

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter handing out one timed interval on a shared 4-bit counter.
// Optional RUN abort is enabled by defining TIMER_ABORT_EN.
module interval_timer_arbiter (
    input  logic                     clk,
    input  logic                     rst,
    interval_timer_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q;
    logic [3:0] q_q;
    logic [3:0] durl_q;
    logic [2:0] gnt_q;
    logic [2:0] done_q;
    logic       busy_q;
    logic [1:0] rr_q;

    logic       win_vld;
    logic [1:0] win_idx;
    logic [2:0] win_oh;
    logic [3:0] win_dur;
    logic [1:0] gnt_idx;
    logic [1:0] rr_d;
    logic       at_end;

    // Search order rr, rr+1, rr+2 (mod 3); first asserted request wins.
    always_comb begin
        win_vld = |bus.req;
        win_idx = 2'd0;
        unique case (rr_q)
            2'd1: begin
                if (bus.req[1])      win_idx = 2'd1;
                else if (bus.req[2]) win_idx = 2'd2;
                else                 win_idx = 2'd0;
            end
            2'd2: begin
                if (bus.req[2])      win_idx = 2'd2;
                else if (bus.req[0]) win_idx = 2'd0;
                else                 win_idx = 2'd1;
            end
            default: begin
                if (bus.req[0])      win_idx = 2'd0;
                else if (bus.req[1]) win_idx = 2'd1;
                else                 win_idx = 2'd2;
            end
        endcase
    end

    always_comb begin
        win_oh  = 3'b000;
        win_dur = 4'd0;
        unique case (win_idx)
            2'd1: begin
                win_oh  = 3'b010;
                win_dur = bus.dur1;
            end
            2'd2: begin
                win_oh  = 3'b100;
                win_dur = bus.dur2;
            end
            default: begin
                win_oh  = 3'b001;
                win_dur = bus.dur0;
            end
        endcase
    end

    always_comb begin
        gnt_idx = 2'd0;
        unique case (1'b1)
            gnt_q[2]: gnt_idx = 2'd2;
            gnt_q[1]: gnt_idx = 2'd1;
            default:  gnt_idx = 2'd0;
        endcase
    end

    assign rr_d   = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    assign at_end = (q_q == durl_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= 4'd0;
            durl_q  <= 4'd0;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            busy_q  <= 1'b0;
            rr_q    <= 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    q_q    <= 4'd0;
                    done_q <= 3'b000;
                    if (win_vld) begin
                        state_q <= RUN;
                        gnt_q   <= win_oh;
                        durl_q  <= win_dur;
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q  <= 3'b000;
                        busy_q <= 1'b0;
                    end
                end
                RUN: begin
`ifdef TIMER_ABORT_EN
                    if (bus.abort) begin
                        state_q <= IDLE;
                        q_q     <= 4'd0;
                        gnt_q   <= 3'b000;
                        busy_q  <= 1'b0;
                        rr_q    <= rr_d;
                    end else
`endif
                    if (at_end) begin
                        state_q <= DONE;
                        done_q  <= gnt_q;
                    end else begin
                        q_q <= q_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    q_q     <= 4'd0;
                    gnt_q   <= 3'b000;
                    done_q  <= 3'b000;
                    busy_q  <= 1'b0;
                    rr_q    <= rr_d;
                end
                default: begin
                    state_q <= IDLE;
                    q_q     <= 4'd0;
                    gnt_q   <= 3'b000;
                    done_q  <= 3'b000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter; abort steps run when
// TIMER_ABORT_EN is defined.
module tb_interval_timer_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    interval_timer_arbiter_if bus();

    interval_timer_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input int g, input int d,
                           input int b, input int qv);
        chk({tag, ".gnt"},  int'(bus.gnt),  g);
        chk({tag, ".done"}, int'(bus.done), d);
        chk({tag, ".busy"}, int'(bus.busy), b);
        chk({tag, ".q"},    int'(bus.q),    qv);
    endtask

    initial begin
        int exp_g [4];
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req  = 3'b000;
        bus.dur0 = 4'd0;
        bus.dur1 = 4'd0;
        bus.dur2 = 4'd0;
`ifdef TIMER_ABORT_EN
        bus.abort = 1'b0;
`endif
        step();
        step();
        chk_all("reset", 0, 0, 0, 0);

        // basic interval, dur0=3
        rst      = 1'b0;
        bus.req  = 3'b001;
        bus.dur0 = 4'd3;
        step();
        chk_all("t1.grant", 1, 0, 1, 0);
        bus.req = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_all($sformatf("t1.run%0d", i), 1, 0, 1, i);
        end
        step();
        chk_all("t1.done", 1, 1, 1, 3);
        step();
        chk_all("t1.idle", 0, 0, 0, 0);

        // round robin with zero durations
        rst = 1'b1;
        step();
        rst      = 1'b0;
        bus.req  = 3'b111;
        bus.dur0 = 4'd0;
        exp_g[0] = 1;
        exp_g[1] = 2;
        exp_g[2] = 4;
        exp_g[3] = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("t2.run%0d", k), exp_g[k], 0, 1, 0);
            step();
            chk_all($sformatf("t2.done%0d", k), exp_g[k], exp_g[k], 1, 0);
            step();
            if (k == 3) bus.req = 3'b000;
            chk_all($sformatf("t2.idle%0d", k), 0, 0, 0, 0);
        end

        // max duration, no wrap; rr now 1
        bus.req  = 3'b010;
        bus.dur1 = 4'd15;
        step();
        chk_all("t3.grant", 2, 0, 1, 0);
        bus.req = 3'b000;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk_all($sformatf("t3.run%0d", i), 2, 0, 1, i);
        end
        step();
        chk_all("t3.done", 2, 2, 1, 15);
        step();
        chk_all("t3.idle", 0, 0, 0, 0);

        // reset mid-interval
        bus.req  = 3'b001;
        bus.dur0 = 4'd5;
        step();
        chk_all("t4.run0", 1, 0, 1, 0);
        bus.req = 3'b000;
        step();
        step();
        chk_all("t4.run2", 1, 0, 1, 2);
        rst = 1'b1;
        step();
        chk_all("t4.rst", 0, 0, 0, 0);
        rst     = 1'b0;
        bus.req = 3'b011;
        step();
        chk_all("t4.regrant", 1, 0, 1, 0);
        bus.req = 3'b000;
        rst     = 1'b1;
        step();
        rst = 1'b0;

        // dur/req changes after grant are ignored
        bus.req  = 3'b100;
        bus.dur2 = 4'd4;
        step();
        chk_all("t5.run0", 4, 0, 1, 0);
        bus.dur2 = 4'd1;
        bus.req  = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_all($sformatf("t5.run%0d", i), 4, 0, 1, i);
        end
        step();
        chk_all("t5.done", 4, 4, 1, 4);
        step();
        chk_all("t5.idle", 0, 0, 0, 0);

`ifdef TIMER_ABORT_EN
        rst = 1'b1;
        step();
        rst      = 1'b0;
        bus.req  = 3'b011;
        bus.dur0 = 4'd7;
        step();
        chk_all("t6.run0", 1, 0, 1, 0);
        step();
        step();
        chk_all("t6.run2", 1, 0, 1, 2);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_all("t6.abort", 0, 0, 0, 0);
        step();
        chk_all("t6.next", 2, 0, 1, 0);
        bus.req = 3'b000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interval_timer_arbiter.md
INTERVAL_TIMER_ARBITER -- requirements
Module: interval_timer_arbiter

Interface
REQ-001: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-002: rst  input  1  reset, synchronous and active-high.
REQ-003: req  input  3  level requests; bit i = requester i wants one timed interval.
REQ-004: dur0, dur1, dur2  input  4 each  interval length for requester 0/1/2, sampled at grant.
REQ-005: gnt  output  3  one-hot registered grant; all-zero when idle.
REQ-006: busy  output  1  high while an interval is granted (RUN or DONE state).
REQ-007: done  output  3  one-cycle pulse on bit i when requester i's interval ends.
REQ-008: q  output  4  current value of the internal shared 4-bit up-counter.
REQ-009: abort  input  1  present only when TIMER_ABORT_EN is defined (see Configuration).

Function
REQ-010: The block SHALL contain one shared 4-bit synchronous up-counter and a three-state FSM: IDLE, RUN, DONE.
REQ-011: IDLE: gnt=000, busy=0, q held at 0; if req!=000, the block SHALL select one requester round-robin and enter RUN next cycle.
REQ-012: Round-robin: search starts at pointer rr (0..2) and proceeds rr, rr+1, rr+2 mod 3; the first asserted req bit wins.
REQ-013: On the IDLE->RUN edge: gnt SHALL become one-hot for the winner, q SHALL be 0, the winner's dur SHALL be latched into dur_l.
REQ-014: Grant latency: req asserted in IDLE on cycle N -> gnt visible on cycle N+1.
REQ-015: RUN: if q==dur_l, the next state SHALL be DONE with q held; otherwise q SHALL increment by 1; RUN therefore lasts exactly dur_l+1 cycles.
REQ-016: q SHALL never wrap: dur_l max is 15, reached before any increment past 15.
REQ-017: Changes on dur0..dur2 after the grant SHALL NOT affect the active interval.
REQ-018: Deassertion of the granted req during RUN SHALL be ignored; the interval runs to completion.
REQ-019: DONE lasts one cycle: done bit of the granted requester =1, gnt held, busy=1; rr SHALL update to (granted index+1) mod 3; the next state SHALL be IDLE with q cleared to 0.
REQ-020: Requests arriving during RUN/DONE SHALL be held pending (level) and arbitrated on the next IDLE cycle.
REQ-021: A requester holding req continuously SHALL receive a further interval no sooner than one IDLE cycle after its DONE.
REQ-022: gnt and done SHALL be one-hot or zero at all times; at most one done bit per interval.

Reset
REQ-023: rst high at a clock edge SHALL force state=IDLE, q=0, gnt=000, done=000, busy=0, rr=0, dur_l=0, regardless of current state.
REQ-024: Reset during RUN SHALL abandon the interval without any done pulse.
REQ-025: The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-026: Macro TIMER_ABORT_EN SHALL control the abort feature.
REQ-027: With TIMER_ABORT_EN defined: abort high in RUN SHALL force the next state to IDLE, q=0, gnt=000, no done pulse; rr SHALL still advance past the aborted requester; abort SHALL be ignored in IDLE and DONE.
REQ-028: Without TIMER_ABORT_EN: the abort port SHALL NOT exist and RUN SHALL end only via REQ-015 or reset.

Verification
REQ-029: After rst, req=001, dur0=3 -> gnt=001 next cycle; q 0,1,2,3 over 4 RUN cycles; done=001 one cycle; then IDLE with q=0.
REQ-030: req=111, dur0=dur1=dur2=0 held -> grants in order 001,010,100,001; each RUN 1 cycle; done pulses in same order.
REQ-031: dur1=15, req=010 -> RUN 16 cycles, q reaches 15 with no wrap, done=010 once.
REQ-032: Grant req=001, dur0=5; rst at 3rd RUN cycle -> next cycle gnt=000, q=0, busy=0, no done; next req=011 grants 001.
REQ-033: dur2=4 granted, dur2 changed to 1 on the 2nd RUN cycle and req2 dropped -> interval still lasts 5 RUN cycles, done=100.
REQ-034: With TIMER_ABORT_EN, req=011, dur0=7; abort at q=2 -> next cycle IDLE, no done; following grant goes to requester 1 (gnt=010).
